// File: rtl/uart_pkg.sv
// Shared UART types: parity mode selector and transmitter state encoding.
// Also used by the receiver, so keep enumerator names stable.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Unused upper bits must be zero so they do not disturb the reduction.
  function automatic logic calc_parity(input parity_t mode, input logic [8:0] data);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake between a byte source and the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: captures one word on the handshake and serialises it as
// start, LSB-first data, optional parity and stop bits, paced by an external tick.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter int      OVERSAMPLE = 16,
  parameter parity_t PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  uart_tx_frame_if.slave  up,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 32) begin : g_bad_oversample
    $error("uart_tx_frame: OVERSAMPLE must be 4..32");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [CNT_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic                 ready_q;
  logic                 period_end;

  assign period_end   = tick && (tick_cnt == TICK_LAST);
  assign up.din_ready = ready_q;

  // ready_q is held low for the first IDLE cycle after a frame, which gives
  // the one-cycle gap between tx_done_tick and the next acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= TX_IDLE;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      stop_cnt     <= 1'b0;
      ready_q      <= 1'b1;
      tx           <= 1'b1;
      busy         <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      if (state != TX_IDLE && tick) begin
        tick_cnt <= period_end ? '0 : tick_cnt + CNT_W'(1);
      end

      unique case (state)
        TX_IDLE: begin
          ready_q <= 1'b1;
          if (up.din_valid && ready_q) begin
            shift_q  <= up.din;
            parity_q <= calc_parity(PARITY, 9'(up.din));
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            ready_q  <= 1'b0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= TX_START;
          end
        end

        TX_START: begin
          if (period_end) begin
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            state   <= TX_DATA;
          end
        end

        TX_DATA: begin
          if (period_end) begin
            if (bit_idx == IDX_LAST) begin
              if (PARITY != PARITY_NONE) begin
                tx    <= parity_q;
                state <= TX_PARITY;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= TX_STOP;
              end
            end else begin
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end

        TX_PARITY: begin
          if (period_end) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= TX_STOP;
          end
        end

        TX_STOP: begin
          if (period_end) begin
            if (stop_cnt == STOP_LAST) begin
              busy         <= 1'b0;
              tx_done_tick <= 1'b1;
              state        <= TX_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          ready_q <= 1'b1;
          state   <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parameterisations share clock, reset and tick;
// a frame model expands each accepted word into expected line bits.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int OS = 16;
  localparam int GUARD = 5000;

  typedef struct {
    int         cfg;
    logic [8:0] word;
    int         nbits;
    bit         has_par;
    logic       par;
    int         nstop;
    int         div;
    int         exp_ticks;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  int         tick_div = 1;
  int         sel = 0;
  logic [8:0] din_drv = '0;
  logic       valid_drv = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;
  logic       exp_q[$];
  vec_t       vecs[7];

  logic tx0, busy0, done0;
  logic tx1, busy1, done1;
  logic tx2, busy2, done2;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if2 ();

  assign if0.din       = din_drv[7:0];
  assign if1.din       = din_drv[6:0];
  assign if2.din       = din_drv[7:0];
  assign if0.din_valid = valid_drv && (sel == 0);
  assign if1.din_valid = valid_drv && (sel == 1);
  assign if2.din_valid = valid_drv && (sel == 2);

  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .up(if0),
    .tx(tx0), .busy(busy0), .tx_done_tick(done0)
  );

  uart_tx_frame #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(PARITY_EVEN), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .up(if1),
    .tx(tx1), .busy(busy1), .tx_done_tick(done1)
  );

  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PARITY_ODD), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .up(if2),
    .tx(tx2), .busy(busy2), .tx_done_tick(done2)
  );

  always #5 clk = ~clk;

  // Tick changes only on the falling edge so it is stable at every posedge.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      tick = (phase == 0);
      phase = (phase + 1) % tick_div;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Packs {tx, busy, tx_done_tick, din_ready} of the selected instance.
  function automatic logic [3:0] dut_out(input int c);
    case (c)
      0:       return {tx0, busy0, done0, if0.din_ready};
      1:       return {tx1, busy1, done1, if1.din_ready};
      default: return {tx2, busy2, done2, if2.din_ready};
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cfg %0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [8:0] word);
    @(negedge clk);
    din_drv   = word;
    valid_drv = 1'b1;
    check_output("ready_before_accept", 32'(dut_out(sel) & 4'b0001), 32'h1);
    @(posedge clk);
  endtask

  // Called right after the accepting posedge; returns on a negedge one cycle
  // after tx_done_tick with din_ready expected high.
  task automatic track_frame(input logic [8:0] word, input int nbits, input bit has_par,
                             input logic par, input int nstop, input int exp_ticks,
                             input bit keep_valid, input logic [8:0] later_din);
    int cnt;
    int ticks;
    int guard;
    cnt = 0;
    ticks = 0;
    guard = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) exp_q.push_back(word[i]);
    if (has_par) exp_q.push_back(par);
    for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);

    @(negedge clk);
    if (!keep_valid) valid_drv = 1'b0;
    din_drv = later_din;
    while (exp_q.size() != 0 && guard < GUARD) begin
      check_output("frame_cycle", 32'(dut_out(sel)), 32'({exp_q[0], 1'b1, 1'b0, 1'b0}));
      @(posedge clk);
      if (tick) begin
        ticks++;
        cnt++;
        if (cnt == OS) begin
          void'(exp_q.pop_front());
          cnt = 0;
        end
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= GUARD) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL frame_timeout: got %0d cycles required under %0d", guard, GUARD);
    end
    check_output("frame_end", 32'(dut_out(sel)), 32'b1010);
    check_output("frame_ticks", 32'(ticks), 32'(exp_ticks));
    @(negedge clk);
    check_output("after_done", 32'(dut_out(sel)), 32'b1001);
  endtask

  initial begin
    int ticks;
    int guard;

    // Parity bits are worked out by hand from the data ones count.
    vecs[0] = '{0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1, 160};
    vecs[1] = '{1, 9'h053, 7, 1'b1, 1'b0, 2, 1, 176};
    vecs[2] = '{2, 9'h000, 8, 1'b1, 1'b1, 1, 1, 176};
    vecs[3] = '{2, 9'h0FF, 8, 1'b1, 1'b1, 1, 1, 176};
    vecs[4] = '{0, 9'h03C, 8, 1'b0, 1'b0, 1, 4, 160};
    vecs[5] = '{1, 9'h02A, 7, 1'b1, 1'b1, 2, 1, 176};
    vecs[6] = '{2, 9'h001, 8, 1'b1, 1'b0, 1, 1, 176};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      sel = c;
      check_output("reset_state", 32'(dut_out(c)), 32'b1001);
    end
    rst = 1'b0;

    // Ticks arriving while idle must not start or disturb anything.
    repeat (20) @(negedge clk);
    sel = 0;
    check_output("idle_ticks", 32'(dut_out(0)), 32'b1001);

    for (int i = 0; i < $size(vecs); i++) begin
      sel      = vecs[i].cfg;
      tick_div = vecs[i].div;
      apply_stimulus(vecs[i].word);
      track_frame(vecs[i].word, vecs[i].nbits, vecs[i].has_par, vecs[i].par,
                  vecs[i].nstop, vecs[i].exp_ticks, 1'b0, ~vecs[i].word);
    end

    // Back-to-back: valid stays high, din switches to the next word mid-frame.
    sel = 0;
    tick_div = 1;
    apply_stimulus(9'h011);
    track_frame(9'h011, 8, 1'b0, 1'b0, 1, 160, 1'b1, 9'h022);
    @(posedge clk);
    track_frame(9'h022, 8, 1'b0, 1'b0, 1, 160, 1'b0, 9'h0AA);

    // Reset during data bit 3 of 0x52 (bit 3 is 0, so the line is low there).
    sel = 0;
    apply_stimulus(9'h052);
    @(negedge clk);
    valid_drv = 1'b0;
    din_drv   = '0;
    ticks = 0;
    guard = 0;
    while (ticks < OS * 4 + 5 && guard < GUARD) begin
      @(posedge clk);
      if (tick) ticks++;
      guard++;
    end
    @(negedge clk);
    check_output("pre_reset_bit3", 32'(dut_out(0)), 32'b0100);
    rst = 1'b1;
    @(negedge clk);
    check_output("reset_mid_frame", 32'(dut_out(0)), 32'b1001);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check_output("after_abort", 32'(dut_out(0)), 32'b1001);
    end
    apply_stimulus(9'h03C);
    track_frame(9'h03C, 8, 1'b0, 1'b0, 1, 160, 1'b0, 9'h0C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
